// File: rtl/corelet_sequencer.sv
// corelet_sequencer
//   Generates the 35-bit corelet instruction word for one pass. A pass runs:
//   kernel fetch from xmem into L0 (WS only), kernel load, a weight
//   propagation gap (WS only), activation fetch (L0 in WS, IFIFO in OS),
//   execute, a wait for OFIFO data, and an OFIFO-to-pmem drain.
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     start        one-cycle pulse, accepted only in IDLE
//     mode         0 = weight stationary, 1 = output stationary
//     num_act      activation vectors per pass (0 behaves as 1)
//     w_base       xmem address of the first weight vector
//     x_base       xmem address of the first activation vector
//     p_base       pmem address of the first output vector
//     fifo_full    L0 (WS) / IFIFO (OS) full, blocks new xmem reads
//     ofifo_valid  OFIFO holds at least one full row
//     busy         high for the active part of a pass
//     done         one-cycle pulse when the pass completes
//     inst         registered instruction word
//
//   inst is registered, so the next-state logic decides the action of the
//   cycle that follows the current edge. state_q always names the phase that
//   the word currently on inst belongs to.
module corelet_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [len_bw-1:0]  num_act,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               fifo_full,
  input  logic               ofifo_valid,
  output logic               busy,
  output logic               done,
  output logic [34:0]        inst
);

  localparam int GAP      = row + col;
  localparam int GAP_BITS = $clog2(GAP + 1);
  localparam int CNT_W    = ((GAP_BITS > len_bw) ? GAP_BITS : len_bw) + 1;

  localparam logic [CNT_W-1:0] COL_C     = CNT_W'(col);
  localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP);
  localparam logic [34:0]      INST_IDLE = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE, K_FETCH, K_LOAD, K_GAP, A_FETCH, A_EXEC, DRAIN, OUT, FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic               ord_q, ord_d;
  logic [34:0]        inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               mode_q;
  logic [len_bw-1:0]  nact_q;
  logic [addr_bw-1:0] wb_q, xb_q, pb_q;

  logic               acc;
  logic               mode_c;
  logic [len_bw-1:0]  nsel;
  logic [CNT_W-1:0]   nact_c;
  logic [addr_bw-1:0] wb_c, xb_c, pb_c;

  logic [CNT_W-1:0]   c;
  logic [CNT_W-1:0]   lim;
  logic               wr_d, pw_d, l0rd_d, kl_d, exe_d, ird_d;
  logic [addr_bw-1:0] xa_d, pa_d;

  // Base plus offset, wrapping silently modulo 2^addr_bw.
  function automatic logic [addr_bw-1:0] addr_at(input logic [addr_bw-1:0] base,
                                                 input logic [CNT_W-1:0]   off);
    return base + addr_bw'(off);
  endfunction

  // On the accepting edge the first action must already use the new
  // configuration, so the live inputs stand in for the latched copies.
  assign acc    = (state_q == IDLE) && start;
  assign mode_c = acc ? mode   : mode_q;
  assign nsel   = acc ? num_act : nact_q;
  assign nact_c = (nsel == '0) ? CNT_W'(1) : CNT_W'(nsel);
  assign wb_c   = acc ? w_base : wb_q;
  assign xb_c   = acc ? x_base : xb_q;
  assign pb_c   = acc ? p_base : pb_q;

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      ord_q   <= 1'b0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ord_q   <= ord_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin : cfg_latch
    if (acc) begin
      mode_q <= mode;
      nact_q <= num_act;
      wb_q   <= w_base;
      xb_q   <= x_base;
      pb_q   <= p_base;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = mode ? A_FETCH : K_FETCH;
      // Fetch phases end only once the last read's delayed write is on inst.
      K_FETCH: if (cnt_q == COL_C && !rd_q) state_d = K_LOAD;
      K_LOAD:  if (cnt_q == COL_C) state_d = K_GAP;
      K_GAP:   if (cnt_q == GAP_C) state_d = A_FETCH;
      A_FETCH: if (cnt_q == nact_c && !rd_q) state_d = A_EXEC;
      A_EXEC:  if (cnt_q == nact_c) state_d = DRAIN;
      DRAIN:   if (ofifo_valid) state_d = OUT;
      OUT:     if (cnt_q == nact_c && !ord_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counters restart on every phase change.
    c      = (state_d == state_q) ? cnt_q : '0;
    lim    = '0;
    cnt_d  = '0;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    ord_d  = 1'b0;
    pw_d   = 1'b0;
    l0rd_d = 1'b0;
    kl_d   = 1'b0;
    exe_d  = 1'b0;
    ird_d  = 1'b0;
    xa_d   = '0;
    pa_d   = '0;

    case (state_d)
      K_FETCH, A_FETCH: begin
        // cnt counts reads issued; a full FIFO holds it but never blocks the
        // write that trails a read already on inst.
        lim   = (state_d == K_FETCH) ? COL_C : nact_c;
        rd_d  = (c < lim) && !fifo_full;
        xa_d  = addr_at((state_d == K_FETCH) ? wb_c : xb_c, c);
        cnt_d = c + CNT_W'(rd_d);
        wr_d  = rd_q;
      end
      K_LOAD: begin
        cnt_d  = c + CNT_W'(1);
        l0rd_d = 1'b1;
        kl_d   = 1'b1;
      end
      K_GAP: begin
        cnt_d = c + CNT_W'(1);
      end
      A_EXEC: begin
        cnt_d  = c + CNT_W'(1);
        exe_d  = 1'b1;
        l0rd_d = !mode_c;
        ird_d  = mode_c;
      end
      OUT: begin
        // cnt counts OFIFO reads; the pmem write trails each read by a cycle
        // and takes the index of that read.
        ord_d = (c < nact_c) && ofifo_valid;
        cnt_d = c + CNT_W'(ord_d);
        pw_d  = ord_q;
        pa_d  = addr_at(pb_c, cnt_q - CNT_W'(1));
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin : output_logic
    inst_d = INST_IDLE;
    if (state_d != IDLE) inst_d[34] = mode_c;
    if (rd_d) begin
      inst_d[19]   = 1'b0;
      inst_d[17:7] = xa_d;
    end
    if (pw_d) begin
      inst_d[32]    = 1'b0;
      inst_d[31]    = 1'b0;
      inst_d[30:20] = pa_d;
    end
    inst_d[6] = ord_d;
    inst_d[5] = ird_d;
    inst_d[4] = wr_d & mode_c;
    inst_d[3] = l0rd_d;
    inst_d[2] = wr_d & ~mode_c;
    inst_d[1] = exe_d;
    inst_d[0] = kl_d;
    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_corelet_sequencer.sv
// tb_corelet_sequencer
//   Directed bench for corelet_sequencer (row = col = 8). Each pass records
//   inst/busy/done once per cycle at the falling edge; index 0 of a trace is
//   the cycle right after the accepting edge. Expected addresses and cycle
//   indices are worked out by hand from the phase lengths.
module tb_corelet_sequencer;

  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int LEN_BW  = 8;
  localparam int ADDR_BW = 11;
  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  logic               clk = 1'b0;
  logic               reset, start, mode, fifo_full, ofifo_valid;
  logic [LEN_BW-1:0]  num_act;
  logic [ADDR_BW-1:0] w_base, x_base, p_base;
  logic               busy, done;
  logic [34:0]        inst;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] tr[$];
  logic        tbz[$];
  logic        tdn[$];
  int          xr_a[$], xr_i[$], pw_a[$], pw_i[$];
  int          orphan;

  always #5 clk = ~clk;

  corelet_sequencer #(
    .row(ROW), .col(COL), .len_bw(LEN_BW), .addr_bw(ADDR_BW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_act(num_act),
    .w_base(w_base), .x_base(x_base), .p_base(p_base),
    .fifo_full(fifo_full), .ofifo_valid(ofifo_valid),
    .busy(busy), .done(done), .inst(inst)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    tr.push_back(inst);
    tbz.push_back(busy);
    tdn.push_back(done);
  endtask

  function automatic int cnt_bit(input int b, input logic v, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < tr.size(); i++)
      if (tr[i][b] === v) n++;
    return n;
  endfunction

  function automatic int cnt_idle(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi && i < tr.size(); i++)
      if (tr[i][6:0] == 7'd0 && tr[i][32] && tr[i][31] && tr[i][19] && tr[i][18]) n++;
    return n;
  endfunction

  function automatic int cnt_done();
    int n = 0;
    for (int i = 0; i < tdn.size(); i++)
      if (tdn[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic extract();
    xr_a.delete(); xr_i.delete(); pw_a.delete(); pw_i.delete();
    orphan = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (!tr[i][19] && tr[i][18]) begin
        xr_a.push_back(int'(tr[i][17:7]));
        xr_i.push_back(i);
      end
      if (!tr[i][32] && !tr[i][31]) begin
        pw_a.push_back(int'(tr[i][30:20]));
        pw_i.push_back(i);
      end
      if ((tr[i][2] || tr[i][4]) && (i == 0 || tr[i-1][19])) orphan++;
    end
  endtask

  // Inputs change at the falling edge right after trace index i is sampled,
  // so they steer the decision taken at the end of cycle i.
  task automatic run_pass(input logic m, input int na, input int wb, input int xb,
                          input int pb, input int ncyc, input int ov_rise,
                          input int dlo, input int dhi, input int flo, input int fhi,
                          input int sp_at, input int rst_at);
    tr.delete(); tbz.delete(); tdn.delete();
    mode = m;
    num_act = LEN_BW'(na);
    w_base = ADDR_BW'(wb);
    x_base = ADDR_BW'(xb);
    p_base = ADDR_BW'(pb);
    fifo_full = 1'b0;
    ofifo_valid = 1'b0;
    start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      start = (i == sp_at);
      reset = (i == rst_at);
      fifo_full = (i >= flo) && (i <= fhi);
      ofifo_valid = (i >= ov_rise) && !((i >= dlo) && (i <= dhi));
    end
    start = 1'b0;
    reset = 1'b0;
    fifo_full = 1'b0;
    ofifo_valid = 1'b0;
    extract();
  endtask

  initial begin
    // Reset from arbitrary inputs
    reset = 1'b1;
    start = 1'($urandom_range(0, 1));
    mode = 1'($urandom_range(0, 1));
    num_act = LEN_BW'($urandom);
    w_base = ADDR_BW'($urandom);
    x_base = ADDR_BW'($urandom);
    p_base = ADDR_BW'($urandom);
    fifo_full = 1'($urandom_range(0, 1));
    ofifo_valid = 1'($urandom_range(0, 1));
    repeat (3) cyc();
    chk("rst_inst", longint'(inst), longint'(IDLE_INST));
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    reset = 1'b0; start = 1'b0; fifo_full = 1'b0; ofifo_valid = 1'b0;
    repeat (2) cyc();
    chk("idle_inst", longint'(inst), longint'(IDLE_INST));

    // WS, N=4. K_FETCH 0-8, K_LOAD 9-16, K_GAP 17-32, A_FETCH 33-37,
    // A_EXEC 38-41, DRAIN 42-43, OUT 44-48, FIN 49.
    run_pass(1'b0, 4, 16, 300, 500, 55, 43, -1, -1, -1, -1, -1, -1);
    chk("ws_nreads", xr_a.size(), 12);
    for (int k = 0; k < 8; k++) begin
      chk("ws_waddr", xr_a[k], 16 + k);
      chk("ws_wcyc", xr_i[k], k);
    end
    for (int k = 0; k < 4; k++) begin
      chk("ws_xaddr", xr_a[8+k], 300 + k);
      chk("ws_xcyc", xr_i[8+k], 33 + k);
    end
    chk("ws_l0wr", cnt_bit(2, 1'b1, 0, 54), 12);
    chk("ws_orphan_wr", orphan, 0);
    chk("ws_kl_win", cnt_bit(0, 1'b1, 9, 16), 8);
    chk("ws_kl_all", cnt_bit(0, 1'b1, 0, 54), 8);
    chk("ws_l0rd", cnt_bit(3, 1'b1, 0, 54), 12);
    chk("ws_gap_idle", cnt_idle(17, 32), 16);
    chk("ws_exec_win", cnt_bit(1, 1'b1, 38, 41), 4);
    chk("ws_exec_all", cnt_bit(1, 1'b1, 0, 54), 4);
    chk("ws_ififo", cnt_bit(4, 1'b1, 0, 54) + cnt_bit(5, 1'b1, 0, 54), 0);
    chk("ws_ordwin", cnt_bit(6, 1'b1, 44, 47), 4);
    chk("ws_ordall", cnt_bit(6, 1'b1, 0, 54), 4);
    chk("ws_npw", pw_a.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("ws_paddr", pw_a[k], 500 + k);
      chk("ws_pcyc", pw_i[k], 45 + k);
    end
    chk("ws_ndone", cnt_done(), 1);
    chk("ws_done_at", longint'(tdn[49]), 1);
    chk("ws_busy0", longint'(tbz[0]), 1);
    chk("ws_busy48", longint'(tbz[48]), 1);
    chk("ws_busy49", longint'(tbz[49]), 0);
    chk("ws_mode_bit", cnt_bit(34, 1'b1, 0, 54), 0);
    chk("ws_after", longint'(tr[50]), longint'(IDLE_INST));

    // OS, N=3. A_FETCH 0-3, A_EXEC 4-6, DRAIN 7-8, OUT 9-12, FIN 13.
    run_pass(1'b1, 3, 0, 10, 20, 20, 8, -1, -1, -1, -1, -1, -1);
    chk("os_nreads", xr_a.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("os_xaddr", xr_a[k], 10 + k);
      chk("os_xcyc", xr_i[k], k);
    end
    chk("os_ififo_wr", cnt_bit(4, 1'b1, 1, 3), 3);
    chk("os_orphan_wr", orphan, 0);
    chk("os_l0", cnt_bit(2, 1'b1, 0, 19) + cnt_bit(3, 1'b1, 0, 19), 0);
    chk("os_kl", cnt_bit(0, 1'b1, 0, 19), 0);
    chk("os_ififo_rd", cnt_bit(5, 1'b1, 4, 6), 3);
    chk("os_exec", cnt_bit(1, 1'b1, 0, 19), 3);
    chk("os_mode_pass", cnt_bit(34, 1'b1, 0, 13), 14);
    chk("os_mode_idle", longint'(tr[14][34]), 0);
    chk("os_npw", pw_a.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("os_paddr", pw_a[k], 20 + k);
      chk("os_pcyc", pw_i[k], 10 + k);
    end
    chk("os_ndone", cnt_done(), 1);
    chk("os_done_at", longint'(tdn[13]), 1);

    // OS backpressure, N=8, fifo_full seen at the ends of cycles 2-6.
    // Reads 0-2 and 8-12, only the trailing write lands in 3-7, FIN at 32.
    run_pass(1'b1, 8, 0, 100, 200, 40, 22, -1, -1, 2, 6, -1, -1);
    chk("bp_nreads", xr_a.size(), 8);
    for (int k = 0; k < 8; k++) chk("bp_xaddr", xr_a[k], 100 + k);
    chk("bp_cyc2", xr_i[2], 2);
    chk("bp_cyc3", xr_i[3], 8);
    chk("bp_reads_stall", cnt_bit(19, 1'b0, 3, 7), 0);
    chk("bp_wr_stall", cnt_bit(4, 1'b1, 3, 7), 1);
    chk("bp_wr_at3", longint'(tr[3][4]), 1);
    chk("bp_nwr", cnt_bit(4, 1'b1, 0, 39), 8);
    chk("bp_orphan_wr", orphan, 0);
    chk("bp_npw", pw_a.size(), 8);
    chk("bp_plast", pw_a[7], 207);
    chk("bp_ndone", cnt_done(), 1);
    chk("bp_done_at", longint'(tdn[32]), 1);

    // Address wrap plus OFIFO stall, OS N=4. OUT 10-17, pmem writes at
    // 11,12,16,17, FIN 18.
    run_pass(1'b1, 4, 0, 2046, 2045, 25, 9, 11, 13, -1, -1, -1, -1);
    chk("wr_nreads", xr_a.size(), 4);
    chk("wr_x0", xr_a[0], 2046);
    chk("wr_x1", xr_a[1], 2047);
    chk("wr_x2", xr_a[2], 0);
    chk("wr_x3", xr_a[3], 1);
    chk("wr_npw", pw_a.size(), 4);
    chk("wr_p0", pw_a[0], 2045);
    chk("wr_p1", pw_a[1], 2046);
    chk("wr_p2", pw_a[2], 2047);
    chk("wr_p3", pw_a[3], 0);
    chk("wr_pc1", pw_i[1], 12);
    chk("wr_pc2", pw_i[2], 16);
    chk("wr_ord_stall", cnt_bit(6, 1'b1, 12, 14), 0);
    chk("wr_ord_all", cnt_bit(6, 1'b1, 0, 24), 4);
    chk("wr_ndone", cnt_done(), 1);
    chk("wr_done_at", longint'(tdn[18]), 1);

    // WS N=4, stray start in A_EXEC (cycle 39), reset at the end of cycle 40.
    run_pass(1'b0, 4, 40, 60, 80, 60, 0, -1, -1, -1, -1, 39, 40);
    chk("rm_exec40", longint'(tr[40][1]), 1);
    chk("rm_busy40", longint'(tbz[40]), 1);
    chk("rm_inst41", longint'(tr[41]), longint'(IDLE_INST));
    chk("rm_busy41", longint'(tbz[41]), 0);
    chk("rm_nreads", xr_a.size(), 12);
    chk("rm_reads_after", cnt_bit(19, 1'b0, 41, 59), 0);
    chk("rm_wr_after", cnt_bit(2, 1'b1, 41, 59), 0);
    chk("rm_npw", pw_a.size(), 0);
    chk("rm_ndone", cnt_done(), 0);

    // Fresh WS pass, N=2: A_FETCH 33-35, DRAIN 38, OUT 39-41, FIN 42.
    run_pass(1'b0, 2, 5, 7, 9, 50, 0, -1, -1, -1, -1, -1, -1);
    chk("nw_nreads", xr_a.size(), 10);
    chk("nw_w0", xr_a[0], 5);
    chk("nw_w7", xr_a[7], 12);
    chk("nw_x0", xr_a[8], 7);
    chk("nw_x1", xr_a[9], 8);
    chk("nw_xcyc", xr_i[8], 33);
    chk("nw_kl", cnt_bit(0, 1'b1, 9, 16), 8);
    chk("nw_npw", pw_a.size(), 2);
    chk("nw_p0", pw_a[0], 9);
    chk("nw_p1", pw_a[1], 10);
    chk("nw_pc0", pw_i[0], 40);
    chk("nw_ndone", cnt_done(), 1);
    chk("nw_done_at", longint'(tdn[42]), 1);
    chk("nw_after", longint'(tr[43]), longint'(IDLE_INST));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
